// File: rtl/l1_mem_arbiter.sv
// Shares one memory request/response channel between the L1 I-cache (port 0)
// and D-cache (port 1): D-side priority, I-side anti-starvation, tag-routed responses.

module l1_mem_arb_outstanding #(
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic accept,
    input  logic retire,
    output logic full,
    output logic underflow
);
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    logic [CNT_W-1:0] count;

    // A retire against an empty counter is flagged, never wrapped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count <= '0;
        else if (accept && !retire)
            count <= count + 1'b1;
        else if (retire && !accept && count != '0)
            count <= count - 1'b1;
    end

    assign full      = (count >= CNT_W'(MAX_OUTSTANDING));
    assign underflow = retire && (count == '0);
endmodule

module l1_mem_arbiter #(
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 32,
    parameter int ID_W            = 4,
    parameter int MAX_OUTSTANDING = 4,
    parameter int STARVE_LIMIT    = 8
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [1:0]          req_valid_i,
    output logic [1:0]          req_ready_o,
    input  logic [2*ADDR_W-1:0] req_addr_i,
    input  logic [1:0]          req_write_i,
    input  logic [2*DATA_W-1:0] req_wdata_i,
    input  logic [2*ID_W-1:0]   req_id_i,
    output logic [1:0]          rsp_valid_o,
    input  logic [1:0]          rsp_ready_i,
    output logic [DATA_W-1:0]   rsp_rdata_o,
    output logic                rsp_error_o,
    output logic [ID_W-1:0]     rsp_id_o,
    output logic                mem_req_valid_o,
    input  logic                mem_req_ready_i,
    output logic [ADDR_W-1:0]   mem_req_addr_o,
    output logic                mem_req_write_o,
    output logic [DATA_W-1:0]   mem_req_wdata_o,
    output logic [ID_W:0]       mem_req_id_o,
    input  logic                mem_rsp_valid_i,
    output logic                mem_rsp_ready_o,
    input  logic [DATA_W-1:0]   mem_rsp_data_i,
    input  logic                mem_rsp_error_i,
    input  logic [ID_W:0]       mem_rsp_id_i,
    output logic                protocol_err_o
);
    typedef enum logic {IDLE, LOCKED} state_t;

    state_t     state;
    logic       owner;
    logic [7:0] starve;
    logic [1:0] full;
    logic [1:0] underflow;
    logic [1:0] eligible;
    logic [1:0] granted;
    logic [1:0] accept;
    logic [1:0] retire;
    logic       win;
    logic       sel;
    logic       rsp_port;

    assign eligible = req_valid_i & ~full;

    always_comb begin
        if (starve == 8'(STARVE_LIMIT) && eligible[0])
            win = 1'b0;
        else if (eligible[1])
            win = 1'b1;
        else
            win = 1'b0;
    end

    // Once memory stalls, the registered owner is the only port forwarded.
    assign sel = (state == LOCKED) ? owner : win;

    always_comb begin
        granted = 2'b00;
        if (!rst_i) begin
            if (state == LOCKED)
                granted[owner] = 1'b1;
            else if (eligible[win])
                granted[win] = 1'b1;
        end
    end

    assign mem_req_valid_o = |granted;
    assign mem_req_addr_o  = sel ? req_addr_i[2*ADDR_W-1 -: ADDR_W] : req_addr_i[ADDR_W-1:0];
    assign mem_req_write_o = req_write_i[sel];
    assign mem_req_wdata_o = sel ? req_wdata_i[2*DATA_W-1 -: DATA_W] : req_wdata_i[DATA_W-1:0];
    assign mem_req_id_o    = {sel, (sel ? req_id_i[2*ID_W-1 -: ID_W] : req_id_i[ID_W-1:0])};

    assign req_ready_o = granted & {2{mem_req_ready_i}};
    assign accept      = req_ready_o;

    // Responses are routed by the port bit the request was tagged with.
    assign rsp_port        = mem_rsp_id_i[ID_W];
    assign mem_rsp_ready_o = !rst_i && rsp_ready_i[rsp_port];
    assign rsp_rdata_o     = mem_rsp_data_i;
    assign rsp_error_o     = mem_rsp_error_i;
    assign rsp_id_o        = mem_rsp_id_i[ID_W-1:0];

    always_comb begin
        rsp_valid_o = 2'b00;
        if (!rst_i)
            rsp_valid_o[rsp_port] = mem_rsp_valid_i;
    end

    assign retire = (mem_rsp_valid_i && mem_rsp_ready_o) ? (rsp_port ? 2'b10 : 2'b01) : 2'b00;

    for (genvar n = 0; n < 2; n++) begin : g_port
        l1_mem_arb_outstanding #(
            .MAX_OUTSTANDING(MAX_OUTSTANDING)
        ) u_outstanding (
            .clk      (clk_i),
            .rst      (rst_i),
            .accept   (accept[n]),
            .retire   (retire[n]),
            .full     (full[n]),
            .underflow(underflow[n])
        );
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
            owner <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (mem_req_valid_o && !mem_req_ready_i) begin
                        state <= LOCKED;
                        owner <= win;
                    end
                end
                LOCKED: begin
                    if (mem_req_ready_i)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Counts D-side wins only while the I-side is actually waiting.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            starve <= '0;
        else if (!req_valid_i[0] || accept[0])
            starve <= '0;
        else if (accept[1] && starve != 8'(STARVE_LIMIT))
            starve <= starve + 1'b1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            protocol_err_o <= 1'b0;
        else if (|underflow)
            protocol_err_o <= 1'b1;
    end
endmodule

// File: tb/tb_l1_mem_arbiter.sv
// Bench for l1_mem_arbiter: directed scenarios plus randomized traffic checked
// against a transaction-level reference model.

module tb_l1_mem_arbiter;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int ID_W   = 4;
    localparam int MAXO   = 4;
    localparam int SLIM   = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]          req_valid, req_ready, req_write, rsp_valid, rsp_ready;
    logic [2*ADDR_W-1:0] req_addr;
    logic [2*DATA_W-1:0] req_wdata;
    logic [2*ID_W-1:0]   req_id;
    logic [DATA_W-1:0]   rsp_rdata;
    logic                rsp_error;
    logic [ID_W-1:0]     rsp_id;
    logic                mem_req_valid, mem_req_ready, mem_req_write;
    logic [ADDR_W-1:0]   mem_req_addr;
    logic [DATA_W-1:0]   mem_req_wdata;
    logic [ID_W:0]       mem_req_id;
    logic                mem_rsp_valid, mem_rsp_ready, mem_rsp_error;
    logic [DATA_W-1:0]   mem_rsp_data;
    logic [ID_W:0]       mem_rsp_id;
    logic                protocol_err;

    int n_cmp = 0;
    int n_bad = 0;

    l1_mem_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W),
        .MAX_OUTSTANDING(MAXO), .STARVE_LIMIT(SLIM)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_addr_i(req_addr),
        .req_write_i(req_write), .req_wdata_i(req_wdata), .req_id_i(req_id),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
        .rsp_error_o(rsp_error), .rsp_id_o(rsp_id),
        .mem_req_valid_o(mem_req_valid), .mem_req_ready_i(mem_req_ready),
        .mem_req_addr_o(mem_req_addr), .mem_req_write_o(mem_req_write),
        .mem_req_wdata_o(mem_req_wdata), .mem_req_id_o(mem_req_id),
        .mem_rsp_valid_i(mem_rsp_valid), .mem_rsp_ready_o(mem_rsp_ready),
        .mem_rsp_data_i(mem_rsp_data), .mem_rsp_error_i(mem_rsp_error),
        .mem_rsp_id_i(mem_rsp_id), .protocol_err_o(protocol_err)
    );

    // Reference model: transaction-level view of arbitration state.
    bit             m_locked;
    int             m_owner;
    int             m_out [2];
    int             m_starve;
    bit             m_perr;
    logic [ID_W:0]  mem_q [$];

    function automatic logic [1:0] exp_grant();
        bit e0, e1;
        e0 = req_valid[0] && (m_out[0] < MAXO);
        e1 = req_valid[1] && (m_out[1] < MAXO);
        if (m_locked) return (m_owner == 1) ? 2'b10 : 2'b01;
        if (m_starve == SLIM && e0) return 2'b01;
        if (e1) return 2'b10;
        if (e0) return 2'b01;
        return 2'b00;
    endfunction

    function automatic void model_update();
        logic [1:0] g, acc;
        int p;
        bit rh;
        if (rst) begin
            m_locked = 0; m_owner = 0; m_out[0] = 0; m_out[1] = 0;
            m_starve = 0; m_perr = 0; mem_q.delete();
            return;
        end
        g   = exp_grant();
        acc = mem_req_ready ? g : 2'b00;
        p   = mem_rsp_id[ID_W] ? 1 : 0;
        rh  = mem_rsp_valid && rsp_ready[p];
        for (int n = 0; n < 2; n++) begin
            bit inc, dec;
            logic pb;
            inc = acc[n];
            dec = rh && (p == n);
            pb  = (n == 1);
            if (dec && m_out[n] == 0) m_perr = 1;
            if (inc && !dec) m_out[n]++;
            else if (dec && !inc && m_out[n] > 0) m_out[n]--;
            if (inc) mem_q.push_back({pb, req_id[n*ID_W +: ID_W]});
        end
        if (rh) begin
            for (int i = 0; i < mem_q.size(); i++)
                if (mem_q[i] == mem_rsp_id) begin mem_q.delete(i); break; end
        end
        if (!req_valid[0] || acc[0]) m_starve = 0;
        else if (acc[1] && m_starve < SLIM) m_starve++;
        if (m_locked) begin
            if (mem_req_ready) m_locked = 0;
        end else if (g != 2'b00 && !mem_req_ready) begin
            m_locked = 1;
            m_owner  = g[1] ? 1 : 0;
        end
    endfunction

    task automatic tick();
        model_update();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0; req_id = '0;
        rsp_ready = '0; mem_req_ready = 0; mem_rsp_valid = 0; mem_rsp_data = '0;
        mem_rsp_error = 0; mem_rsp_id = '0;
    endtask

    task automatic set_req(input int p, input logic v, input logic [ADDR_W-1:0] a,
                           input logic w, input logic [DATA_W-1:0] d, input logic [ID_W-1:0] id);
        req_valid[p] = v;
        req_addr[p*ADDR_W +: ADDR_W] = a;
        req_write[p] = w;
        req_wdata[p*DATA_W +: DATA_W] = d;
        req_id[p*ID_W +: ID_W] = id;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1;
        tick();
        rst = 0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1; req_valid = 2'b11; mem_req_ready = 1; mem_rsp_valid = 1; rsp_ready = 2'b11;
        #1;
        n_cmp++; if (mem_req_valid !== 1'b0) begin n_bad++; $display("FAIL reset_mem_req_valid got %0h exp 0", mem_req_valid); end
        n_cmp++; if (req_ready !== 2'b00) begin n_bad++; $display("FAIL reset_req_ready got %0h exp 0", req_ready); end
        n_cmp++; if (rsp_valid !== 2'b00) begin n_bad++; $display("FAIL reset_rsp_valid got %0h exp 0", rsp_valid); end
        n_cmp++; if (mem_rsp_ready !== 1'b0) begin n_bad++; $display("FAIL reset_mem_rsp_ready got %0h exp 0", mem_rsp_ready); end
        n_cmp++; if (protocol_err !== 1'b0) begin n_bad++; $display("FAIL reset_protocol_err got %0h exp 0", protocol_err); end
        tick();
        rst = 0;
        clear_inputs();
    endtask

    task automatic test_port1_read();
        do_reset();
        set_req(1, 1, 32'h100, 0, 0, 4'h3);
        mem_req_ready = 1;
        #1;
        n_cmp++; if (mem_req_valid !== 1'b1) begin n_bad++; $display("FAIL p1_read_valid got %0h exp 1", mem_req_valid); end
        n_cmp++; if (mem_req_id !== 5'h13) begin n_bad++; $display("FAIL p1_read_id got %0h exp 13", mem_req_id); end
        n_cmp++; if (mem_req_addr !== 32'h100) begin n_bad++; $display("FAIL p1_read_addr got %0h exp 100", mem_req_addr); end
        n_cmp++; if (req_ready !== 2'b10) begin n_bad++; $display("FAIL p1_read_ready got %0h exp 2", req_ready); end
        tick();
        clear_inputs();
        mem_rsp_valid = 1; mem_rsp_id = 5'h13; mem_rsp_data = 32'hDEADBEEF; rsp_ready = 2'b11;
        #1;
        n_cmp++; if (rsp_valid !== 2'b10) begin n_bad++; $display("FAIL p1_rsp_valid got %0h exp 2", rsp_valid); end
        n_cmp++; if (rsp_rdata !== 32'hDEADBEEF) begin n_bad++; $display("FAIL p1_rsp_data got %0h exp deadbeef", rsp_rdata); end
        n_cmp++; if (rsp_id !== 4'h3) begin n_bad++; $display("FAIL p1_rsp_id got %0h exp 3", rsp_id); end
        n_cmp++; if (mem_rsp_ready !== 1'b1) begin n_bad++; $display("FAIL p1_rsp_ready got %0h exp 1", mem_rsp_ready); end
        tick();
        clear_inputs();
    endtask

    task automatic test_starve();
        logic [1:0] exp;
        do_reset();
        set_req(0, 1, 32'h200, 0, 0, 4'h1);
        set_req(1, 1, 32'h100, 0, 0, 4'h2);
        mem_req_ready = 1;
        rsp_ready = 2'b11;
        for (int c = 0; c < 10; c++) begin
            // Retire port-1 responses to keep it below the outstanding cap.
            mem_rsp_valid = (c >= 1 && c != 8);
            mem_rsp_id = 5'h12;
            #1;
            exp = (c == 8) ? 2'b01 : 2'b10;
            n_cmp++; if (req_ready !== exp) begin n_bad++; $display("FAIL starve_cycle%0d got %0h exp %0h", c, req_ready, exp); end
            if (c == 8) begin
                n_cmp++; if (mem_req_id !== 5'h01) begin n_bad++; $display("FAIL starve_forced_id got %0h exp 01", mem_req_id); end
            end
            tick();
        end
        n_cmp++; if (protocol_err !== 1'b0) begin n_bad++; $display("FAIL starve_perr got %0h exp 0", protocol_err); end
        clear_inputs();
    endtask

    task automatic test_lock();
        do_reset();
        set_req(0, 1, 32'h200, 1, 32'hCAFE, 4'h5);
        mem_req_ready = 0;
        for (int c = 0; c < 3; c++) begin
            if (c == 2) set_req(1, 1, 32'h300, 0, 0, 4'h6);
            #1;
            n_cmp++; if (mem_req_valid !== 1'b1) begin n_bad++; $display("FAIL lock_valid_c%0d got %0h exp 1", c, mem_req_valid); end
            n_cmp++; if (mem_req_addr !== 32'h200) begin n_bad++; $display("FAIL lock_addr_c%0d got %0h exp 200", c, mem_req_addr); end
            n_cmp++; if (mem_req_id !== 5'h05) begin n_bad++; $display("FAIL lock_id_c%0d got %0h exp 05", c, mem_req_id); end
            n_cmp++; if (req_ready !== 2'b00) begin n_bad++; $display("FAIL lock_ready_c%0d got %0h exp 0", c, req_ready); end
            tick();
        end
        mem_req_ready = 1;
        #1;
        n_cmp++; if (req_ready !== 2'b01) begin n_bad++; $display("FAIL lock_release_ready got %0h exp 1", req_ready); end
        n_cmp++; if (mem_req_wdata !== 32'hCAFE || mem_req_write !== 1'b1) begin n_bad++; $display("FAIL lock_release_wdata got %0h/%0h exp cafe/1", mem_req_wdata, mem_req_write); end
        tick();
        #1;
        n_cmp++; if (req_ready !== 2'b10) begin n_bad++; $display("FAIL lock_next_ready got %0h exp 2", req_ready); end
        n_cmp++; if (mem_req_addr !== 32'h300) begin n_bad++; $display("FAIL lock_next_addr got %0h exp 300", mem_req_addr); end
        tick();
        clear_inputs();
    endtask

    task automatic test_outstanding();
        do_reset();
        mem_req_ready = 1;
        for (int c = 0; c < 4; c++) begin
            set_req(1, 1, 32'h1000 + 32'(c), 0, 0, 4'(c));
            #1;
            n_cmp++; if (req_ready !== 2'b10) begin n_bad++; $display("FAIL outst_fill%0d got %0h exp 2", c, req_ready); end
            tick();
        end
        set_req(0, 1, 32'h200, 0, 0, 4'h9);
        #1;
        n_cmp++; if (req_ready !== 2'b01) begin n_bad++; $display("FAIL outst_p0_ready got %0h exp 1", req_ready); end
        n_cmp++; if (mem_req_addr !== 32'h200) begin n_bad++; $display("FAIL outst_p0_addr got %0h exp 200", mem_req_addr); end
        tick();
        set_req(0, 0, 0, 0, 0, 0);
        #1;
        n_cmp++; if (mem_req_valid !== 1'b0) begin n_bad++; $display("FAIL outst_full_valid got %0h exp 0", mem_req_valid); end
        tick();
        mem_rsp_valid = 1; mem_rsp_id = 5'h10; rsp_ready = 2'b10;
        #1;
        n_cmp++; if (rsp_valid !== 2'b10) begin n_bad++; $display("FAIL outst_rsp_valid got %0h exp 2", rsp_valid); end
        n_cmp++; if (req_ready !== 2'b00) begin n_bad++; $display("FAIL outst_rsp_cycle_ready got %0h exp 0", req_ready); end
        tick();
        mem_rsp_valid = 0;
        #1;
        n_cmp++; if (req_ready !== 2'b10) begin n_bad++; $display("FAIL outst_restored got %0h exp 2", req_ready); end
        tick();
        clear_inputs();
    endtask

    task automatic test_rsp_backpressure();
        do_reset();
        set_req(0, 1, 32'h40, 0, 0, 4'h7);
        mem_req_ready = 1;
        #1;
        n_cmp++; if (req_ready !== 2'b01) begin n_bad++; $display("FAIL bp_first_ready got %0h exp 1", req_ready); end
        tick();
        set_req(0, 0, 0, 0, 0, 0);
        mem_rsp_valid = 1; mem_rsp_id = 5'h07; mem_rsp_data = 32'h1234; rsp_ready = 2'b10;
        #1;
        n_cmp++; if (mem_rsp_ready !== 1'b0) begin n_bad++; $display("FAIL bp_mem_rsp_ready got %0h exp 0", mem_rsp_ready); end
        n_cmp++; if (rsp_valid !== 2'b01) begin n_bad++; $display("FAIL bp_rsp_valid got %0h exp 1", rsp_valid); end
        n_cmp++; if (rsp_rdata !== 32'h1234) begin n_bad++; $display("FAIL bp_rsp_data got %0h exp 1234", rsp_rdata); end
        tick();
        rsp_ready = 2'b01;
        set_req(0, 1, 32'h44, 0, 0, 4'h8);
        #1;
        n_cmp++; if (mem_rsp_ready !== 1'b1 || req_ready !== 2'b01) begin n_bad++; $display("FAIL bp_simul got %0h/%0h exp 1/1", mem_rsp_ready, req_ready); end
        tick();
        mem_rsp_valid = 0;
        // One entry still outstanding: exactly three more fit.
        for (int c = 0; c < 3; c++) begin
            #1;
            n_cmp++; if (req_ready !== 2'b01) begin n_bad++; $display("FAIL bp_fill%0d got %0h exp 1", c, req_ready); end
            tick();
        end
        #1;
        n_cmp++; if (req_ready !== 2'b00 || mem_req_valid !== 1'b0) begin n_bad++; $display("FAIL bp_full got %0h/%0h exp 0/0", req_ready, mem_req_valid); end
        n_cmp++; if (protocol_err !== 1'b0) begin n_bad++; $display("FAIL bp_perr got %0h exp 0", protocol_err); end
        tick();
        clear_inputs();
    endtask

    task automatic test_protocol_err();
        do_reset();
        mem_rsp_valid = 1; mem_rsp_id = 5'h01; rsp_ready = 2'b01;
        #1;
        n_cmp++; if (rsp_valid !== 2'b01) begin n_bad++; $display("FAIL perr_fwd got %0h exp 1", rsp_valid); end
        n_cmp++; if (protocol_err !== 1'b0) begin n_bad++; $display("FAIL perr_early got %0h exp 0", protocol_err); end
        tick();
        mem_rsp_valid = 0;
        #1;
        n_cmp++; if (protocol_err !== 1'b1) begin n_bad++; $display("FAIL perr_set got %0h exp 1", protocol_err); end
        tick(); tick();
        n_cmp++; if (protocol_err !== 1'b1) begin n_bad++; $display("FAIL perr_sticky got %0h exp 1", protocol_err); end
        set_req(1, 1, 32'h500, 0, 0, 4'h2);
        mem_req_ready = 0;
        tick();
        rst = 1; mem_rsp_valid = 1; mem_rsp_id = 5'h10; rsp_ready = 2'b11;
        #1;
        n_cmp++; if (mem_req_valid !== 1'b0 || req_ready !== 2'b00) begin n_bad++; $display("FAIL midrst_req got %0h/%0h exp 0/0", mem_req_valid, req_ready); end
        n_cmp++; if (rsp_valid !== 2'b00 || mem_rsp_ready !== 1'b0) begin n_bad++; $display("FAIL midrst_rsp got %0h/%0h exp 0/0", rsp_valid, mem_rsp_ready); end
        n_cmp++; if (protocol_err !== 1'b0) begin n_bad++; $display("FAIL midrst_perr got %0h exp 0", protocol_err); end
        tick();
        rst = 0;
        clear_inputs();
        set_req(0, 1, 32'h600, 0, 0, 4'h4);
        mem_req_ready = 1;
        #1;
        n_cmp++; if (req_ready !== 2'b01 || mem_req_addr !== 32'h600) begin n_bad++; $display("FAIL midrst_idle got %0h/%0h exp 1/600", req_ready, mem_req_addr); end
        tick();
        clear_inputs();
    endtask

    task automatic test_random();
        logic [1:0] eg, erv;
        logic       s;
        logic [ID_W-1:0] eid;
        logic [ADDR_W-1:0] ea;
        int p;
        do_reset();
        rsp_ready = 2'b11;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int n = 0; n < 2; n++) begin
                if (!(m_locked && m_owner == n))
                    set_req(n, ($urandom_range(0, 9) < ((n == 1) ? 7 : 6)), $urandom, 1'($urandom),
                            $urandom, 4'($urandom));
            end
            mem_req_ready = 1'($urandom);
            rsp_ready = 2'($urandom);
            mem_rsp_data = $urandom;
            mem_rsp_error = 1'($urandom);
            if (mem_q.size() > 0 && $urandom_range(0, 2) != 0) begin
                mem_rsp_valid = 1;
                mem_rsp_id = mem_q[$urandom_range(0, mem_q.size() - 1)];
            end else begin
                mem_rsp_valid = 0;
                mem_rsp_id = 5'($urandom);
            end
            #1;
            eg = exp_grant();
            n_cmp++; if (mem_req_valid !== (eg != 2'b00)) begin n_bad++; $display("FAIL rnd%0d mem_req_valid got %0h exp %0h", cyc, mem_req_valid, eg != 2'b00); end
            n_cmp++; if (req_ready !== (eg & {2{mem_req_ready}})) begin n_bad++; $display("FAIL rnd%0d req_ready got %0h exp %0h", cyc, req_ready, eg & {2{mem_req_ready}}); end
            if (eg != 2'b00) begin
                s   = eg[1];
                eid = req_id[(s ? 1 : 0)*ID_W +: ID_W];
                ea  = req_addr[(s ? 1 : 0)*ADDR_W +: ADDR_W];
                n_cmp++; if (mem_req_id !== {s, eid} || mem_req_addr !== ea) begin n_bad++; $display("FAIL rnd%0d fwd got %0h/%0h exp %0h/%0h", cyc, mem_req_id, mem_req_addr, {s, eid}, ea); end
            end
            p   = mem_rsp_id[ID_W] ? 1 : 0;
            erv = mem_rsp_valid ? ((p == 1) ? 2'b10 : 2'b01) : 2'b00;
            n_cmp++; if (rsp_valid !== erv || mem_rsp_ready !== rsp_ready[p]) begin n_bad++; $display("FAIL rnd%0d rsp got %0h/%0h exp %0h/%0h", cyc, rsp_valid, mem_rsp_ready, erv, rsp_ready[p]); end
            n_cmp++; if (protocol_err !== m_perr) begin n_bad++; $display("FAIL rnd%0d perr got %0h exp %0h", cyc, protocol_err, m_perr); end
            tick();
        end
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_port1_read();
        test_starve();
        test_lock();
        test_outstanding();
        test_rsp_backpressure();
        test_protocol_err();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
